// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package param_counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Widest count the Gray helper supports; callers cast down to their width.
   localparam int GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] gray_enc(input logic [GRAY_MAX_W-1:0] v);
      return v ^ (v >> 1);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the enable stream: one tick every PRESCALE enabled clocks.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase_q, phase_d;

   // With PRESCALE=1 the phase never leaves 0, so tick degenerates to en.
   assign tick = en & ~clr & (phase_q == LAST);

   always_comb begin
      phase_d = phase_q;
      if (clr)
         phase_d = '0;
      else if (en)
         phase_d = tick ? '0 : phase_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) phase_q <= '0;
      else      phase_q <= phase_d;
   end

endmodule

// File: rtl/param_sync_counter.sv
// Parametrised up/down counter with load, wrap/saturate, prescaler,
// Gray output, terminal-count flag and a registered wrap pulse.
module param_sync_counter
   import param_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] gray,
   output logic             tc,
   output logic             wrap
);

   if (WIDTH < 2 || WIDTH > GRAY_MAX_W) begin : g_bad_width
      $error("param_sync_counter: WIDTH out of range");
   end
   if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_mod
      $error("param_sync_counter: MODULUS must be in 2..2**WIDTH");
   end
   if (PRESCALE < 1) begin : g_bad_pre
      $error("param_sync_counter: PRESCALE must be >= 1");
   end

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             tick, at_max, at_zero;

   tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .tick (tick)
   );

   assign at_max  = (count_q == MAX);
   assign at_zero = (count_q == '0);
   assign tc      = (dir == DIR_DOWN) ? at_zero : at_max;
   assign gray    = WIDTH'(gray_enc(GRAY_MAX_W'(count_q)));
   assign count   = count_q;
   assign wrap    = wrap_q;

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = (load_val > MAX) ? MAX : load_val;
      end else if (tick) begin
         if (dir == DIR_UP) begin
            if (!at_max)              count_d = count_q + 1'b1;
            else if (sat == MODE_WRAP) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end
         end else begin
            if (!at_zero)             count_d = count_q - 1'b1;
            else if (sat == MODE_WRAP) begin
               count_d = MAX;
               wrap_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

endmodule

// File: doc/param_sync_counter.md
Name: param_sync_counter

Overview:
Parametrised synchronous up/down counter. It is the general-purpose successor to the team's fixed 4-stage down counter and drives the lab's timers, display sequencers and divided strobes. It adds configurable width and modulus, direction control, parallel load, wrap/saturate mode and an integrated prescaler. It also provides Gray-coded output, a terminal-count flag and a wrap pulse.

Parameters:
- WIDTH, 4, counter width in bits; must be ≥ 2.
- MODULUS, 16, count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH.
- PRESCALE, 1, enabled clk cycles per count step; must be ≥ 1.
- Illegal parameter values stop elaboration with $error.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, count enable; gates the prescaler.
- dir, input, 1, 1 = count up, 0 = count down.
- sat, input, 1, 1 = saturate at terminal, 0 = wrap.
- load, input, 1, synchronous parallel load strobe.
- load_val, input, WIDTH, value to load.
- count, output, WIDTH, binary count; registered.
- gray, output, WIDTH, Gray code of count: count ^ (count >> 1). Combinational from the count register, so zero added latency.
- tc, output, 1, terminal-count flag; combinational.
- wrap, output, 1, registered one-cycle pulse after a wrap step.

Behaviour:
- Reset: rst low asynchronously forces count = 0, prescaler = 0, wrap = 0. Consequently gray = 0 and tc = ~dir. Release takes effect at the next rising clk.
- Priority per edge: reset > load > tick step > hold.
- Load:
  - count <= min(load_val, MODULUS-1).
  - Prescaler clears to 0.
  - wrap <= 0.
  - en is ignored that cycle.
- Prescaler:
  - Increments on each clk with en=1 and load=0.
  - Produces an internal tick when it equals PRESCALE-1 with en=1, then returns to 0.
  - With PRESCALE=1, tick = en.
  - en=0 holds prescaler and count unchanged; no clear.
- Step on tick, with dir and sat sampled on the tick edge:
  - Up, count < MODULUS-1: count+1.
  - Up, count = MODULUS-1: sat=0 → 0 and wrap <= 1; sat=1 → hold, wrap <= 0.
  - Down, count > 0: count-1.
  - Down, count = 0: sat=0 → MODULUS-1 and wrap <= 1; sat=1 → hold.
- wrap: high exactly one cycle, the cycle after the wrapping edge; 0 on every other edge.
- tc = (dir & count == MODULUS-1) | (~dir & count == 0). It follows dir combinationally, so a dir change flips tc in the same cycle.
- Arithmetic:
  - Performed in WIDTH bits.
  - No intermediate value leaves 0..MODULUS-1.
  - count never holds an out-of-range value, including after load.
- Mid-operation dir change: takes effect at the next tick; prescaler phase is kept.
- Mid-count reset: immediate return to reset values regardless of the prescaler phase.

Decomposition:
- Package param_counter_pkg:
  - DIR_UP / DIR_DOWN constants.
  - MODE_WRAP / MODE_SAT constants.
  - A function returning the Gray encoding of a WIDTH-bit value.
- Sub-module tick_prescaler (PRESCALE parameter):
  - Ports: clk, rst, en, clr, tick.
  - Instantiated once.
- Next-state logic: a single combinational always block.
- State register: a single always block, posedge clk / negedge rst.

Test Plan:
1. Defaults, rst pulse low, then en=1, dir=0, sat=0 → count sequence 0, 15, 14 … 1, 0, 15. wrap high only the cycle after the 0→15 step. gray at count=15 is 1000.
2. MODULUS=10, dir=1, en=1 from reset → 0…9, 0. tc=1 only at count=9. wrap one pulse after 9→0. count never reaches 10–15.
3. sat=1, dir=0, load_val=2 loaded, en=1 → 2, 1, 0, 0, 0; wrap stays 0; tc=1 from count=0 onward. Switching dir=1 → tc drops same cycle, count steps to 1 on the next edge.
4. PRESCALE=3, dir=1, en=1 → count advances once every 3 clks. Dropping en for 2 clks mid-phase stretches that step by exactly 2 clks.
5. load=1 with en=1 and load_val=13 under MODULUS=10 → count=9 next edge (clamped), prescaler cleared. load with tick coincident → the load value wins.
6. rst asserted asynchronously mid-count (count=7, prescaler phase 1, wrap=1) → count, wrap and prescaler read 0 before the next clk edge. Counting resumes from 0 on the first edge after release.
